// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline hazard controller.
//   mdu_state_e : MDU tracker FSM states (RUN, MDU_BUSY)
//   hazard_e    : hazard case selected each cycle, lowest to highest priority
//   REG_ZERO    : architectural $0, which never creates a load-use hazard
//   reg_match   : true when a used source field matches a destination
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    LOADUSE  = 3'd1,
    MDU      = 3'd2,
    REDIRECT = 3'd3,
    FREEZE   = 3'd4
  } hazard_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_match(input logic use_f, input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_f && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and stall/bubble
// controls back to it.
//   slave  : the hazard controller (reads i_*, drives o_*)
//   master : the pipeline datapath (drives i_*, reads o_*)
interface pipe_hazard_ctrl_if;
  logic       i_mem_wait;
  logic       i_ex_redirect;
  logic       i_idex_memread;
  logic [4:0] i_idex_rt;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_use_rs;
  logic       i_id_use_rt;
  logic       i_id_hilo_rd;
  logic       i_ex_mdu_start;
  logic       o_pc_we;
  logic       o_ifid_stall;
  logic       o_ifid_bubble;
  logic       o_idex_stall;
  logic       o_idex_bubble;
  logic       o_exmem_stall;
  logic       o_exmem_bubble;
  logic       o_memwb_stall;
  logic       o_memwb_bubble;
  logic       o_mdu_busy;

  modport slave (
    input  i_mem_wait, i_ex_redirect, i_idex_memread, i_idex_rt, i_id_rs,
           i_id_rt, i_id_use_rs, i_id_use_rt, i_id_hilo_rd, i_ex_mdu_start,
    output o_pc_we, o_ifid_stall, o_ifid_bubble, o_idex_stall, o_idex_bubble,
           o_exmem_stall, o_exmem_bubble, o_memwb_stall, o_memwb_bubble,
           o_mdu_busy
  );

  modport master (
    output i_mem_wait, i_ex_redirect, i_idex_memread, i_idex_rt, i_id_rs,
           i_id_rt, i_id_use_rs, i_id_use_rt, i_id_hilo_rd, i_ex_mdu_start,
    input  o_pc_we, o_ifid_stall, o_ifid_bubble, o_idex_stall, o_idex_bubble,
           o_exmem_stall, o_exmem_bubble, o_memwb_stall, o_memwb_bubble,
           o_mdu_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_busy_tracker.sv
// mdu_busy_tracker: follows the multi-cycle mult/div unit with a down-counter
// so ID can be interlocked until HI/LO is valid.
//   clk, rst  : clock, synchronous active-high reset
//   start_acc : mult/div accepted from EX this cycle
//   busy      : counter nonzero (HI/LO not yet valid)
//
// state    | meaning
// RUN      | counter == 0, HI/LO valid
// MDU_BUSY | counter > 0, counting down to HI/LO valid
module mdu_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start_acc,
  output logic busy
);

  localparam logic [7:0] LAT = 8'(MDU_LATENCY);

  mdu_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start while busy restarts the count; the ID interlock normally
  // prevents it, but restarting keeps the tracker conservative.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (start_acc) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = LAT;
        end
      end
      MDU_BUSY: begin
        if (start_acc) begin
          cnt_nxt = LAT;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Picks one hazard case per cycle (freeze > redirect > MDU > load-use > none)
// and maps it onto PC write enable and per-register stall/bubble pairs.
//   clk, rst : clock, synchronous active-high reset (flushes pipeline)
//   hz       : pipe_hazard_ctrl_if.slave, hazard inputs and control outputs
// Optional macro PIPE_HAZARD_PERF_EN adds CNT_W-wide counters
//   o_perf_stall_cnt, o_perf_flush_cnt, o_perf_freeze_cnt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 8
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_hazard_ctrl_if.slave      hz
`ifdef PIPE_HAZARD_PERF_EN
  , output logic [CNT_W-1:0]     o_perf_stall_cnt
  , output logic [CNT_W-1:0]     o_perf_flush_cnt
  , output logic [CNT_W-1:0]     o_perf_freeze_cnt
`endif
);

  logic    start_acc;
  logic    mdu_busy;
  logic    load_use;
  hazard_e hcase;

  // A start is only real if EX advances this cycle and is not squashed.
  assign start_acc = hz.i_ex_mdu_start & ~hz.i_mem_wait & ~hz.i_ex_redirect;

  mdu_busy_tracker #(.MDU_LATENCY(MDU_LATENCY)) u_mdu (
    .clk       (clk),
    .rst       (rst),
    .start_acc (start_acc),
    .busy      (mdu_busy)
  );

  assign load_use = hz.i_idex_memread && (hz.i_idex_rt != REG_ZERO) &&
                    (reg_match(hz.i_id_use_rs, hz.i_id_rs, hz.i_idex_rt) ||
                     reg_match(hz.i_id_use_rt, hz.i_id_rt, hz.i_idex_rt));

  always_comb begin
    if (hz.i_mem_wait)                       hcase = FREEZE;
    else if (hz.i_ex_redirect)               hcase = REDIRECT;
    else if (hz.i_id_hilo_rd && mdu_busy)    hcase = MDU;
    else if (load_use)                       hcase = LOADUSE;
    else                                     hcase = NONE;
  end

  always_comb begin
    hz.o_pc_we        = 1'b1;
    hz.o_ifid_stall   = 1'b0;
    hz.o_ifid_bubble  = 1'b0;
    hz.o_idex_stall   = 1'b0;
    hz.o_idex_bubble  = 1'b0;
    hz.o_exmem_stall  = 1'b0;
    hz.o_exmem_bubble = 1'b0;
    hz.o_memwb_stall  = 1'b0;
    hz.o_memwb_bubble = 1'b0;
    if (rst) begin
      hz.o_pc_we        = 1'b0;
      hz.o_ifid_bubble  = 1'b1;
      hz.o_idex_bubble  = 1'b1;
      hz.o_exmem_bubble = 1'b1;
      hz.o_memwb_bubble = 1'b1;
    end else begin
      case (hcase)
        FREEZE: begin
          hz.o_pc_we       = 1'b0;
          hz.o_ifid_stall  = 1'b1;
          hz.o_idex_stall  = 1'b1;
          hz.o_exmem_stall = 1'b1;
          hz.o_memwb_stall = 1'b1;
        end
        REDIRECT: begin
          hz.o_ifid_bubble = 1'b1;
          hz.o_idex_bubble = 1'b1;
        end
        MDU, LOADUSE: begin
          // Hold the ID instruction, send a bubble into EX.
          hz.o_pc_we       = 1'b0;
          hz.o_ifid_stall  = 1'b1;
          hz.o_idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.o_mdu_busy = mdu_busy;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_stall_cnt  <= '0;
      o_perf_flush_cnt  <= '0;
      o_perf_freeze_cnt <= '0;
    end else begin
      case (hcase)
        MDU, LOADUSE: o_perf_stall_cnt  <= o_perf_stall_cnt + 1'b1;
        REDIRECT:     o_perf_flush_cnt  <= o_perf_flush_cnt + 1'b1;
        FREEZE:       o_perf_freeze_cnt <= o_perf_freeze_cnt + 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule
